// File: rtl/branch_hazard_unit.sv
// rtl/branch_hazard_unit.sv - ID-stage branch forwarding select, hazard stall sequencer and stall counter
module branch_hazard_unit #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int WB_FWD  = 1,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_branch,
    input  logic [NUM_SRC*AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]     id_src_used,
    input  logic [AW-1:0]          ex_rw,
    input  logic                   ex_regwr,
    input  logic                   ex_memtoreg,
    input  logic [AW-1:0]          mem_rw,
    input  logic                   mem_regwr,
    input  logic                   mem_memtoreg,
    input  logic [AW-1:0]          wb_rw,
    input  logic                   wb_regwr,
    input  logic                   cnt_clr,
    output logic [2*NUM_SRC-1:0]   branch_fwd,
    output logic                   stall,
    output logic                   ex_bubble,
    output logic [CNT_W-1:0]       stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hazardState_t;

    hazardState_t hazardState;

    logic [1:0]           chanNeed [NUM_SRC];
    logic [2*NUM_SRC-1:0] fwdSel;
    logic [1:0]           needMax;

    // Per-channel hazard depth and forward source; register 0 is hardwired and never matches
    for (genvar g = 0; g < NUM_SRC; g++) begin : gChan
        logic [AW-1:0] src;
        logic          active;
        logic          exHit;
        logic          memHit;
        logic          wbHit;

        assign src    = id_src[g*AW +: AW];
        assign active = id_branch & id_src_used[g] & (src != '0);
        assign exHit  = ex_regwr  & (ex_rw  == src);
        assign memHit = mem_regwr & (mem_rw == src);
        assign wbHit  = wb_regwr  & (wb_rw  == src);

        // EX producer decides the stall depth even when MEM also matches; MEM loads cost one cycle
        always_comb begin
            chanNeed[g] = 2'd0;
            if (active) begin
                if (exHit) begin
                    chanNeed[g] = ex_memtoreg ? 2'd2 : 2'd1;
                end else if (memHit && mem_memtoreg) begin
                    chanNeed[g] = 2'd1;
                end
            end
        end

        // MEM ALU result beats WB; a MEM load cannot be forwarded so it falls through to regfile
        always_comb begin
            fwdSel[2*g +: 2] = 2'd0;
            if (active) begin
                if (memHit && !mem_memtoreg) begin
                    fwdSel[2*g +: 2] = 2'd1;
                end else if ((WB_FWD != 0) && wbHit) begin
                    fwdSel[2*g +: 2] = 2'd2;
                end
            end
        end
    end

    // Longest stall demanded by any channel sets the sequence length
    always_comb begin
        needMax = 2'd0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (chanNeed[s] > needMax) begin
                needMax = chanNeed[s];
            end
        end
    end

    // Outputs are gated by rst so an asynchronous reset kills a stall mid-cycle
    always_comb begin
        stall      = 1'b0;
        branch_fwd = '0;
        if (!rst) begin
            branch_fwd = fwdSel;
            stall      = (hazardState == HOLD) || (needMax != 2'd0);
        end
    end

    assign ex_bubble = stall;

    // Two-cycle load-use stall: first cycle from IDLE, second cycle spent in HOLD regardless of inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazardState <= IDLE;
        end else begin
            case (hazardState)
                IDLE:    hazardState <= (needMax == 2'd2) ? HOLD : IDLE;
                HOLD:    hazardState <= IDLE;
                default: hazardState <= IDLE;
            endcase
        end
    end

    // Saturating stall-cycle counter; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb/tb_branch_hazard_unit.sv - directed self-checking bench for branch_hazard_unit
module tb_branch_hazard_unit;

    localparam int AW      = 5;
    localparam int NUM_SRC = 2;

    logic                  clk;
    logic                  rst;
    logic                  id_branch;
    logic [NUM_SRC*AW-1:0] id_src;
    logic [NUM_SRC-1:0]    id_src_used;
    logic [AW-1:0]         ex_rw;
    logic                  ex_regwr;
    logic                  ex_memtoreg;
    logic [AW-1:0]         mem_rw;
    logic                  mem_regwr;
    logic                  mem_memtoreg;
    logic [AW-1:0]         wb_rw;
    logic                  wb_regwr;
    logic                  cnt_clr;

    logic [2*NUM_SRC-1:0]  branch_fwd;
    logic                  stall;
    logic                  ex_bubble;
    logic [3:0]            stall_cycles;

    logic [2*NUM_SRC-1:0]  branch_fwd_nw;
    logic                  stall_nw;
    logic                  ex_bubble_nw;
    logic [15:0]           stall_cycles_nw;

    int numChecks = 0;
    int numFails  = 0;

    branch_hazard_unit #(.AW(AW), .NUM_SRC(NUM_SRC), .WB_FWD(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_branch(id_branch), .id_src(id_src), .id_src_used(id_src_used),
        .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
        .mem_rw(mem_rw), .mem_regwr(mem_regwr), .mem_memtoreg(mem_memtoreg),
        .wb_rw(wb_rw), .wb_regwr(wb_regwr), .cnt_clr(cnt_clr),
        .branch_fwd(branch_fwd), .stall(stall), .ex_bubble(ex_bubble), .stall_cycles(stall_cycles)
    );

    branch_hazard_unit #(.AW(AW), .NUM_SRC(NUM_SRC), .WB_FWD(0), .CNT_W(16)) dutNoWb (
        .clk(clk), .rst(rst), .id_branch(id_branch), .id_src(id_src), .id_src_used(id_src_used),
        .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
        .mem_rw(mem_rw), .mem_regwr(mem_regwr), .mem_memtoreg(mem_memtoreg),
        .wb_rw(wb_rw), .wb_regwr(wb_regwr), .cnt_clr(cnt_clr),
        .branch_fwd(branch_fwd_nw), .stall(stall_nw), .ex_bubble(ex_bubble_nw), .stall_cycles(stall_cycles_nw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        id_branch    = 1'b0;
        id_src       = '0;
        id_src_used  = '0;
        ex_rw        = '0;
        ex_regwr     = 1'b0;
        ex_memtoreg  = 1'b0;
        mem_rw       = '0;
        mem_regwr    = 1'b0;
        mem_memtoreg = 1'b0;
        wb_rw        = '0;
        wb_regwr     = 1'b0;
        cnt_clr      = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        clearInputs();
        rst = 1'b1;
        // Hazard present during reset must be masked
        id_branch = 1'b1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
        ex_rw = 5'd5; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_stall", stall, 0);
        checkVal("rst_bubble", ex_bubble, 0);
        checkVal("rst_fwd", branch_fwd, 0);
        checkVal("rst_cnt", stall_cycles, 0);
        nextCycle();
        clearInputs();
        rst = 1'b0;

        // Load r5 in EX, branch on r5 (ch0): two stall cycles
        id_branch = 1'b1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
        ex_rw = 5'd5; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
        #1;
        checkVal("ld_ex_stall1", stall, 1);
        checkVal("ld_ex_bubble1", ex_bubble, 1);
        nextCycle();
        ex_regwr = 1'b0; ex_memtoreg = 1'b0;
        mem_rw = 5'd5; mem_regwr = 1'b1; mem_memtoreg = 1'b1;
        #1;
        checkVal("ld_hold_stall2", stall, 1);
        checkVal("ld_hold_cnt", stall_cycles, 1);
        nextCycle();
        mem_regwr = 1'b0; mem_memtoreg = 1'b0;
        wb_rw = 5'd5; wb_regwr = 1'b1;
        #1;
        checkVal("ld_done_stall", stall, 0);
        checkVal("ld_done_fwd_wb", branch_fwd, 4'b0010);
        checkVal("ld_done_cnt", stall_cycles, 2);

        // ALU op writing r3 in EX, branch on r3 (ch1): one stall then MEM forward
        nextCycle();
        clearInputs();
        id_branch = 1'b1; id_src = {5'd3, 5'd0}; id_src_used = 2'b10;
        ex_rw = 5'd3; ex_regwr = 1'b1;
        #1;
        checkVal("alu_ex_stall", stall, 1);
        nextCycle();
        ex_regwr = 1'b0;
        mem_rw = 5'd3; mem_regwr = 1'b1;
        #1;
        checkVal("alu_mem_stall", stall, 0);
        checkVal("alu_mem_fwd", branch_fwd, 4'b0100);
        checkVal("alu_mem_cnt", stall_cycles, 3);

        // MEM and WB both write r7, both channels read r7
        nextCycle();
        clearInputs();
        id_branch = 1'b1; id_src = {5'd7, 5'd7}; id_src_used = 2'b11;
        mem_rw = 5'd7; mem_regwr = 1'b1;
        wb_rw = 5'd7; wb_regwr = 1'b1;
        #1;
        checkVal("memwb_fwd", branch_fwd, 4'b0101);
        checkVal("memwb_fwd_nowb", branch_fwd_nw, 4'b0101);
        checkVal("memwb_stall", stall, 0);
        nextCycle();
        mem_regwr = 1'b0;
        #1;
        checkVal("wbonly_fwd", branch_fwd, 4'b1010);
        checkVal("wbonly_fwd_nowb", branch_fwd_nw, 4'b0000);

        // Every producer targets r0 and the branch reads r0
        nextCycle();
        clearInputs();
        id_branch = 1'b1; id_src = {5'd0, 5'd0}; id_src_used = 2'b11;
        ex_rw = 5'd0; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
        mem_rw = 5'd0; mem_regwr = 1'b1; mem_memtoreg = 1'b1;
        wb_rw = 5'd0; wb_regwr = 1'b1;
        #1;
        checkVal("r0_stall", stall, 0);
        checkVal("r0_fwd", branch_fwd, 0);

        // Load in MEM on ch0 (r9): one stall, no forward; then WB forward
        nextCycle();
        clearInputs();
        checkVal("r0_cnt", stall_cycles, 3);
        id_branch = 1'b1; id_src = {5'd0, 5'd9}; id_src_used = 2'b01;
        mem_rw = 5'd9; mem_regwr = 1'b1; mem_memtoreg = 1'b1;
        #1;
        checkVal("memld_stall", stall, 1);
        checkVal("memld_fwd", branch_fwd, 0);
        nextCycle();
        mem_regwr = 1'b0; mem_memtoreg = 1'b0;
        wb_rw = 5'd9; wb_regwr = 1'b1;
        #1;
        checkVal("memld_after_stall", stall, 0);
        checkVal("memld_after_fwd", branch_fwd, 4'b0010);
        checkVal("memld_cnt", stall_cycles, 4);

        // HOLD completes even after id_branch drops
        nextCycle();
        clearInputs();
        id_branch = 1'b1; id_src = {5'd6, 5'd0}; id_src_used = 2'b10;
        ex_rw = 5'd6; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
        #1;
        checkVal("nobr_stall1", stall, 1);
        nextCycle();
        clearInputs();
        #1;
        checkVal("nobr_hold_stall", stall, 1);
        checkVal("nobr_hold_fwd", branch_fwd, 0);
        nextCycle();
        #1;
        checkVal("nobr_idle_stall", stall, 0);
        checkVal("nobr_cnt", stall_cycles, 6);

        // Asynchronous reset in the middle of a HOLD cycle
        nextCycle();
        id_branch = 1'b1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
        ex_rw = 5'd5; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
        #1;
        checkVal("rsthold_stall1", stall, 1);
        nextCycle();
        ex_regwr = 1'b0; ex_memtoreg = 1'b0;
        mem_rw = 5'd5; mem_regwr = 1'b1;
        #1;
        checkVal("rsthold_stall_pre", stall, 1);
        checkVal("rsthold_fwd_pre", branch_fwd, 4'b0001);
        checkVal("rsthold_cnt_pre", stall_cycles, 7);
        #1 rst = 1'b1;
        #1;
        checkVal("rsthold_stall_in", stall, 0);
        checkVal("rsthold_bubble_in", ex_bubble, 0);
        checkVal("rsthold_fwd_in", branch_fwd, 0);
        checkVal("rsthold_cnt_in", stall_cycles, 0);
        #1 rst = 1'b0;
        #1;
        checkVal("rsthold_stall_post", stall, 0);
        checkVal("rsthold_fwd_post", branch_fwd, 4'b0001);
        nextCycle();
        #1;
        checkVal("rsthold_cnt_post", stall_cycles, 0);

        // Continuous one-cycle hazard drives the 4-bit counter into saturation
        nextCycle();
        clearInputs();
        id_branch = 1'b1; id_src = {5'd0, 5'd4}; id_src_used = 2'b01;
        ex_rw = 5'd4; ex_regwr = 1'b1;
        repeat (16) nextCycle();
        #1;
        checkVal("sat_stall", stall, 1);
        checkVal("sat_cnt", stall_cycles, 15);
        nextCycle();
        #1;
        checkVal("sat_hold_cnt", stall_cycles, 15);
        checkVal("sat_wide_cnt", stall_cycles_nw, 17);
        cnt_clr = 1'b1;
        nextCycle();
        #1;
        checkVal("clr_cnt", stall_cycles, 0);
        cnt_clr = 1'b0;
        nextCycle();
        #1;
        checkVal("clr_resume_cnt", stall_cycles, 1);

        clearInputs();
        nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
